uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver. Captures each received payload

---
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular FIFO of {break, payload} words
// with a first-word-fall-through read port, level/threshold reporting and sticky overflow.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int THRESHOLD    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rx_valid,
  input  logic [PAYLOAD_BITS-1:0]  rx_data,
  input  logic                     rx_break,
  input  logic                     flush,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PAYLOAD_BITS-1:0]  rd_data,
  output logic                     rd_break,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     irq_thresh,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_L = PW'(THRESHOLD);

  logic [PAYLOAD_BITS:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PAYLOAD_BITS:0] head;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Pointer difference with a wrap bit distinguishes full from empty.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == DEPTH_L);
  assign empty      = (level == '0);
  assign irq_thresh = (level >= THRESH_L);
  assign rd_valid   = !empty;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_data  = rd_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign rd_break = rd_valid ? head[PAYLOAD_BITS] : 1'b0;

  // A pop while full frees the slot being written, so that word is still accepted.
  assign pop  = rd_valid & rd_ready & !flush;
  assign push = rx_valid & (!full | (rd_valid & rd_ready)) & !flush;
  assign drop = rx_valid & full & !(rd_valid & rd_ready) & !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {rx_break, rx_data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Setting beats clearing so a drop in the same cycle as ovf_clear is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic       clk;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       flush;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_break;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       irq_thresh;
  logic       overflow;
  logic       ovf_clear;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  bit         m_ovf = 0;

  logic [18:0] dut_vec;
  localparam logic [18:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};

  assign dut_vec = {rd_valid, rd_break, rd_data, level, full, empty, irq_thresh, overflow};

  uart_rx_fifo dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .flush      (flush),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_break   (rd_break),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .irq_thresh (irq_thresh),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of stored words plus the sticky flag.
  function automatic void model_step(input bit rv, input logic [7:0] d, input bit b,
                                     input bit fl, input bit rr, input bit oc);
    bit pop;
    bit drop;
    int n;
    pop  = (q.size() > 0) && rr;
    drop = 0;
    n    = q.size();
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (rv) begin
        if (n < DEPTH || pop) q.push_back({b, d});
        else drop = 1;
      end
    end
    if (drop) m_ovf = 1;
    else if (oc) m_ovf = 0;
  endfunction

  function automatic logic [18:0] model_out();
    logic [4:0] l;
    logic [8:0] h;
    l = 5'(q.size());
    h = (q.size() > 0) ? q[0] : 9'h000;
    return {q.size() != 0, h[8], h[7:0], l, l == 5'(DEPTH), l == 5'd0,
            int'(l) >= THRESH, m_ovf};
  endfunction

  task automatic drive(input bit rv, input logic [7:0] d, input bit b,
                       input bit fl, input bit rr, input bit oc);
    rx_valid  = rv;
    rx_data   = d;
    rx_break  = b;
    flush     = fl;
    rd_ready  = rr;
    ovf_clear = oc;
    model_step(rv, d, b, fl, rr, oc);
    @(posedge clk);
    #1;
    rx_valid  = 0;
    rx_data   = 0;
    rx_break  = 0;
    flush     = 0;
    rd_ready  = 0;
    ovf_clear = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
    q.delete();
    m_ovf = 0;
  endtask

  task automatic test_basic();
    drive(1, 8'h41, 0, 0, 0, 0);
    drive(1, 8'h42, 0, 0, 0, 0);
    drive(1, 8'h43, 0, 0, 0, 0);
    checks++;
    if ({level, rd_data} !== {5'd3, 8'h41}) begin
      errors++;
      $display("[TB] FAIL basic_level_head: got %0d/%h expected 3/41", level, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== 8'(8'h41 + i)) begin
        errors++;
        $display("[TB] FAIL basic_pop_order: got %h expected %h", rd_data, 8'(8'h41 + i));
      end
      drive(0, 0, 0, 0, 1, 0);
    end
    checks++;
    if ({empty, rd_valid, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL basic_empty: got e=%b v=%b d=%h expected 1/0/00", empty, rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 0, 0, 0);
    drive(1, 8'hAA, 0, 0, 0, 0);
    checks++;
    if ({full, overflow, level} !== {1'b1, 1'b1, 5'd16}) begin
      errors++;
      $display("[TB] FAIL ovf_set: got full=%b ovf=%b lvl=%0d expected 1/1/16", full, overflow, level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL ovf_drain: got %h expected %h", rd_data, 8'(i));
      end
      drive(0, 0, 0, 0, 1, 0);
    end
    checks++;
    if ({empty, overflow} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got empty=%b ovf=%b expected 1/1", empty, overflow);
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 0, 0, 0);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL fpp_head: got %h expected 00", rd_data);
    end
    drive(1, 8'h55, 0, 0, 1, 0);
    checks++;
    if ({level, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fpp_state: got lvl=%0d full=%b ovf=%b expected 16/1/0", level, full, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 8'(i + 1) : 8'h55;
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL fpp_drain: got %h expected %h", rd_data, exp);
      end
      drive(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_break_thresh();
    logic [8:0] exp_words [3];
    exp_words[0] = {1'b0, 8'h11};
    exp_words[1] = {1'b1, 8'h00};
    exp_words[2] = {1'b0, 8'h22};
    for (int i = 0; i < 3; i++) drive(1, exp_words[i][7:0], exp_words[i][8], 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd_break, rd_data} !== exp_words[i]) begin
        errors++;
        $display("[TB] FAIL break_tag: got %b/%h expected %b/%h", rd_break, rd_data,
                 exp_words[i][8], exp_words[i][7:0]);
      end
      drive(0, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 7; i++) drive(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if ({level, irq_thresh} !== {5'd7, 1'b0}) begin
      errors++;
      $display("[TB] FAIL thresh_below: got lvl=%0d irq=%b expected 7/0", level, irq_thresh);
    end
    drive(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if ({level, irq_thresh} !== {5'd8, 1'b1}) begin
      errors++;
      $display("[TB] FAIL thresh_rise: got lvl=%0d irq=%b expected 8/1", level, irq_thresh);
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if ({level, irq_thresh} !== {5'd7, 1'b0}) begin
      errors++;
      $display("[TB] FAIL thresh_fall: got lvl=%0d irq=%b expected 7/0", level, irq_thresh);
    end
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'($urandom), 0, 0, 1, 0);
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got %h expected %h", i, dut_vec, model_out());
      end
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (dut_vec !== model_out()) begin
      errors++;
      $display("[TB] FAIL stream_end: got %h expected %h", dut_vec, model_out());
    end
  endtask

  task automatic test_random();
    bit rv, b, fl, rr, oc;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      rv = $urandom_range(0, 99) < 60;
      rr = $urandom_range(0, 99) < ((i < 200) ? 30 : 70);
      fl = $urandom_range(0, 99) < 2;
      oc = $urandom_range(0, 99) < 5;
      b  = $urandom_range(0, 99) < 10;
      d  = b ? 8'h00 : 8'($urandom);
      drive(rv, d, b, fl, rr, oc);
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, dut_vec, model_out());
      end
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("[TB] FAIL flush_pre: got %0d expected 5", level);
    end
    drive(1, 8'h77, 0, 1, 1, 0);
    checks++;
    if (dut_vec !== {1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_empty: got %h expected %h", dut_vec, RESET_VEC);
    end
    drive(1, 8'h99, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== model_out()) begin
      errors++;
      $display("[TB] FAIL flush_after: got %h expected %h", dut_vec, model_out());
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 8'h01, 0, 0, 0, 0);
    drive(1, 8'h02, 0, 0, 0, 0);
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got %0d expected 3", level);
    end
    resetn = 0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got %h expected %h", dut_vec, RESET_VEC);
    end
    q.delete();
    m_ovf = 0;
    #3;
    resetn = 1;
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== model_out()) begin
      errors++;
      $display("[TB] FAIL rstmid_after: got %h expected %h", dut_vec, model_out());
    end
  endtask

  initial begin
    clk       = 0;
    resetn    = 0;
    rx_valid  = 0;
    rx_data   = 0;
    rx_break  = 0;
    flush     = 0;
    rd_ready  = 0;
    ovf_clear = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_break_thresh();
    test_stream();
    test_random();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
